// File: rtl/buffer_pkg.sv
// -----------------------------------------------------------------------------
// buffer_pkg
// Shared types and constants for buffer_responder.
//   - DATA_W        : width of every stored / returned word
//   - WEIGHT_DEPTH  : number of weight words (pointers wrap 7 -> 0)
//   - DEF_IN_DEPTH  : default input-region capacity
//   - DEF_OUT_DEPTH : default output-region capacity
//   - resp_state_t  : response FSM states
//   - resp_src_t    : which region a pending response reads from
// -----------------------------------------------------------------------------
package buffer_pkg;

    localparam int DATA_W        = 64;
    localparam int WEIGHT_DEPTH  = 8;
    localparam int DEF_IN_DEPTH  = 16;
    localparam int DEF_OUT_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } resp_state_t;

    typedef enum logic {
        SRC_WEIGHT = 1'b0,
        SRC_INPUT  = 1'b1
    } resp_src_t;

endpackage

// File: rtl/flex_counter.sv
// -----------------------------------------------------------------------------
// flex_counter
// Up-counter with a run-time rollover value: when enabled and the count equals
// rollover_val, the next value is 0. A synchronous clear overrides enable.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   clear         : synchronous clear to 0 (wins over enable)
//   enable        : advance by one (or roll over)
//   rollover_val  : last value before wrapping to 0
//   count         : current count
// -----------------------------------------------------------------------------
module flex_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= (count_reg == rollover_val) ? '0 : count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/buffer_responder.sv
// -----------------------------------------------------------------------------
// buffer_responder
// Host-loaded weight/input buffer feeding a systolic array, plus an output
// FIFO that collects array results.
//   Host side : wr_en/wr_sel/wr_data write weights (sel=0) or inputs (sel=1);
//               in_clr empties input+output regions; err_clr clears the sticky
//               occupancy_err; out_rd_en pops out_rd_data (combinational head).
//   Array side: get_weights / get_inputs request the next word; the answer
//               appears on data with a one-cycle data_ready pulse two cycles
//               after the request. array_out/array_out_valid fill the output
//               region; get_out + output_valid yields a single out_done pulse.
//   Status    : num_inputs, output_valid, occupancy_err.
// -----------------------------------------------------------------------------
module buffer_responder
    import buffer_pkg::*;
#(
    parameter int IN_DEPTH  = DEF_IN_DEPTH,
    parameter int OUT_DEPTH = DEF_OUT_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              in_clr,
    input  logic              err_clr,
    input  logic              get_weights,
    input  logic              get_inputs,
    input  logic              get_out,
    input  logic [DATA_W-1:0] array_out,
    input  logic              array_out_valid,
    input  logic              out_rd_en,
    output logic [DATA_W-1:0] data,
    output logic              data_ready,
    output logic [7:0]        num_inputs,
    output logic              out_done,
    output logic              output_valid,
    output logic              occupancy_err,
    output logic [DATA_W-1:0] out_rd_data
);

    localparam int IN_AW  = (IN_DEPTH  > 1) ? $clog2(IN_DEPTH)  : 1;
    localparam int OUT_AW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    // Latched read pointer must hold either a weight index or an input index.
    localparam int PTR_W  = (IN_AW > 3) ? IN_AW : 3;
    localparam logic [7:0]        IN_FULL  = 8'(IN_DEPTH);
    localparam logic [OUT_AW:0]   OUT_FULL = (OUT_AW + 1)'(OUT_DEPTH);
    localparam logic [OUT_AW-1:0] OUT_LAST = OUT_AW'(OUT_DEPTH - 1);

    // ---------------- storage ----------------
    logic [DATA_W-1:0] w_mem   [WEIGHT_DEPTH];
    logic [DATA_W-1:0] in_mem  [IN_DEPTH];
    logic [DATA_W-1:0] out_mem [OUT_DEPTH];

    // ---------------- pointers ----------------
    logic [2:0]       w_wr_ptr;
    logic [2:0]       w_rd_ptr;
    logic [7:0]       in_wr_ptr;
    logic [IN_AW-1:0] in_rd_ptr;
    logic [IN_AW-1:0] in_rd_last;

    // ---------------- response FSM ----------------
    resp_state_t       state_reg;
    resp_src_t         src_reg;
    logic              zero_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [DATA_W-1:0] data_reg;
    logic              data_ready_reg;

    // ---------------- output region ----------------
    logic [OUT_AW-1:0] out_wr_ptr_reg;
    logic [OUT_AW-1:0] out_rd_ptr_reg;
    logic [OUT_AW:0]   out_count_reg;
    logic [7:0]        cap_cnt_reg;
    logic              output_valid_reg;
    logic              out_done_reg;
    logic              done_fired_reg;
    logic              occupancy_err_reg;

    // ---------------- control decode ----------------
    logic idle, serve_w, serve_i, serve_i_ok;
    logic wr_weight, wr_input_ok;
    logic in_ovf_err, in_empty_err, cap_drop_err, pop_err, set_err;
    logic pass_start, cap_clear, cap_full, out_we, pop_ok;
    logic [OUT_AW-1:0] out_wr_idx;

    assign idle         = (state_reg == ST_IDLE);
    assign serve_w      = idle & get_weights;
    assign serve_i      = idle & ~get_weights & get_inputs;
    assign serve_i_ok   = serve_i & (in_wr_ptr != 8'd0);
    assign in_empty_err = serve_i & (in_wr_ptr == 8'd0);

    assign wr_weight    = wr_en & ~wr_sel;
    assign wr_input_ok  = wr_en & wr_sel & ~in_clr & (in_wr_ptr != IN_FULL);
    assign in_ovf_err   = wr_en & wr_sel & ~in_clr & (in_wr_ptr == IN_FULL);

    // Never wider than IN_AW: num_inputs <= IN_DEPTH, so num_inputs-1 fits.
    assign in_rd_last   = IN_AW'(in_wr_ptr - 8'd1);

    // A get_inputs served at read pointer 0 starts a new inference pass, so the
    // previous pass's results are discarded.
    assign pass_start   = serve_i_ok & (in_rd_ptr == '0);
    assign cap_clear    = in_clr | pass_start;
    assign cap_full     = (out_count_reg == OUT_FULL);
    // A capture coinciding with a pass start belongs to the new pass (slot 0).
    assign out_we       = array_out_valid & ~in_clr & (pass_start | ~cap_full);
    assign out_wr_idx   = cap_clear ? '0 : out_wr_ptr_reg;
    assign cap_drop_err = array_out_valid & ~cap_clear & cap_full;
    assign pop_ok       = out_rd_en & ~cap_clear & (out_count_reg != '0);
    assign pop_err      = out_rd_en & ~cap_clear & (out_count_reg == '0);
    assign set_err      = in_ovf_err | in_empty_err | cap_drop_err | pop_err;

    function automatic logic [OUT_AW-1:0] out_next(input logic [OUT_AW-1:0] p);
        return (p == OUT_LAST) ? '0 : p + 1'b1;
    endfunction

    // ---------------- pointer counters ----------------
    flex_counter #(.WIDTH(3)) u_w_wr (
        .clk(clk), .rst(rst), .clear(1'b0), .enable(wr_weight),
        .rollover_val(3'd7), .count(w_wr_ptr)
    );

    flex_counter #(.WIDTH(3)) u_w_rd (
        .clk(clk), .rst(rst), .clear(1'b0), .enable(serve_w),
        .rollover_val(3'd7), .count(w_rd_ptr)
    );

    // Enabled only below IN_FULL, so it saturates rather than wrapping.
    flex_counter #(.WIDTH(8)) u_in_wr (
        .clk(clk), .rst(rst), .clear(in_clr), .enable(wr_input_ok),
        .rollover_val(IN_FULL), .count(in_wr_ptr)
    );

    flex_counter #(.WIDTH(IN_AW)) u_in_rd (
        .clk(clk), .rst(rst), .clear(in_clr), .enable(serve_i_ok),
        .rollover_val(in_rd_last), .count(in_rd_ptr)
    );

    // ---------------- memories (no reset: contents are don't-care) ----------
    always_ff @(posedge clk) begin
        if (wr_weight) begin
            w_mem[w_wr_ptr] <= wr_data;
        end
        if (wr_input_ok) begin
            in_mem[in_wr_ptr[IN_AW-1:0]] <= wr_data;
        end
        if (out_we) begin
            out_mem[out_wr_idx] <= array_out;
        end
    end

    // ---------------- response FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            src_reg        <= SRC_WEIGHT;
            zero_reg       <= 1'b0;
            rd_ptr_reg     <= '0;
            data_reg       <= '0;
            data_ready_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    data_ready_reg <= 1'b0;
                    if (serve_w) begin
                        src_reg    <= SRC_WEIGHT;
                        zero_reg   <= 1'b0;
                        rd_ptr_reg <= PTR_W'(w_rd_ptr);
                        state_reg  <= ST_READ;
                    end else if (serve_i) begin
                        src_reg    <= SRC_INPUT;
                        zero_reg   <= (in_wr_ptr == 8'd0);
                        rd_ptr_reg <= PTR_W'(in_rd_ptr);
                        state_reg  <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (zero_reg) begin
                        data_reg <= '0;
                    end else if (src_reg == SRC_INPUT) begin
                        data_reg <= in_mem[rd_ptr_reg[IN_AW-1:0]];
                    end else begin
                        data_reg <= w_mem[rd_ptr_reg[2:0]];
                    end
                    data_ready_reg <= 1'b1;
                    state_reg      <= ST_RESP;
                end
                ST_RESP: begin
                    data_ready_reg <= 1'b0;
                    state_reg      <= ST_IDLE;
                end
                default: begin
                    data_ready_reg <= 1'b0;
                    state_reg      <= ST_IDLE;
                end
            endcase
        end
    end

    // ---------------- output region ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_wr_ptr_reg <= '0;
            out_rd_ptr_reg <= '0;
            out_count_reg  <= '0;
            cap_cnt_reg    <= '0;
        end else if (cap_clear) begin
            out_rd_ptr_reg <= '0;
            out_wr_ptr_reg <= out_we ? out_next('0) : '0;
            out_count_reg  <= out_we ? (OUT_AW + 1)'(1) : '0;
            cap_cnt_reg    <= out_we ? 8'd1 : 8'd0;
        end else begin
            if (out_we) begin
                out_wr_ptr_reg <= out_next(out_wr_ptr_reg);
                if (cap_cnt_reg != 8'hFF) begin
                    cap_cnt_reg <= cap_cnt_reg + 8'd1;
                end
            end
            if (pop_ok) begin
                out_rd_ptr_reg <= out_next(out_rd_ptr_reg);
            end
            case ({out_we, pop_ok})
                2'b10:   out_count_reg <= out_count_reg + 1'b1;
                2'b01:   out_count_reg <= out_count_reg - 1'b1;
                default: out_count_reg <= out_count_reg;
            endcase
        end
    end

    // Status flags. cap_cnt counts captures since the last clear (pops do not
    // reduce it), so a popped-out result set still reads as complete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            output_valid_reg  <= 1'b0;
            out_done_reg      <= 1'b0;
            done_fired_reg    <= 1'b0;
            occupancy_err_reg <= 1'b0;
        end else begin
            if (cap_clear) begin
                output_valid_reg <= 1'b0;
            end else begin
                output_valid_reg <= (in_wr_ptr != 8'd0) && (cap_cnt_reg == in_wr_ptr);
            end
            // One pulse per get_out assertion; re-armed when get_out drops.
            out_done_reg   <= get_out & output_valid_reg & ~done_fired_reg;
            done_fired_reg <= get_out & (done_fired_reg | output_valid_reg);
            if (err_clr) begin
                occupancy_err_reg <= 1'b0;
            end else if (set_err) begin
                occupancy_err_reg <= 1'b1;
            end
        end
    end

    assign data          = data_reg;
    assign data_ready    = data_ready_reg;
    assign num_inputs    = in_wr_ptr;
    assign out_done      = out_done_reg;
    assign output_valid  = output_valid_reg;
    assign occupancy_err = occupancy_err_reg;
    assign out_rd_data   = out_mem[out_rd_ptr_reg];

endmodule

// File: tb/tb_buffer_responder.sv
// -----------------------------------------------------------------------------
// tb_buffer_responder
// Self-checking bench for buffer_responder. Expected response words are pushed
// onto resp_q when a request is driven and popped when data_ready is due;
// expected output-region words go through out_q the same way.
// -----------------------------------------------------------------------------
module tb_buffer_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, wr_sel, in_clr, err_clr;
    logic [63:0] wr_data;
    logic        get_weights, get_inputs, get_out;
    logic [63:0] array_out;
    logic        array_out_valid, out_rd_en;
    logic [63:0] data;
    logic        data_ready;
    logic [7:0]  num_inputs;
    logic        out_done, output_valid, occupancy_err;
    logic [63:0] out_rd_data;

    int errors = 0;
    int checks = 0;

    logic [63:0] resp_q[$];
    logic [63:0] out_q[$];
    logic [63:0] w_model[8];
    logic [63:0] in_model[16];
    int          w_rd_idx = 0;

    buffer_responder dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .in_clr(in_clr), .err_clr(err_clr), .get_weights(get_weights),
        .get_inputs(get_inputs), .get_out(get_out), .array_out(array_out),
        .array_out_valid(array_out_valid), .out_rd_en(out_rd_en), .data(data),
        .data_ready(data_ready), .num_inputs(num_inputs), .out_done(out_done),
        .output_valid(output_valid), .occupancy_err(occupancy_err),
        .out_rd_data(out_rd_data)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_word(input logic sel, input logic [63:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_clr();
        in_clr = 1'b1;
        tick();
        in_clr = 1'b0;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    // Drives a one-cycle request; returns in cycle N+1.
    task automatic req_pulse(input logic gw, input logic gi);
        get_weights = gw; get_inputs = gi;
        tick();
        get_weights = 1'b0; get_inputs = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (data !== 64'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", data); end
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready got=%b exp=0", data_ready); end
        checks++; if (out_done !== 1'b0) begin errors++; $display("FAIL reset_out_done got=%b exp=0", out_done); end
        checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL reset_output_valid got=%b exp=0", output_valid); end
        checks++; if (occupancy_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", occupancy_err); end
        checks++; if (num_inputs !== 8'd0) begin errors++; $display("FAIL reset_num_inputs got=%0d exp=0", num_inputs); end
        rst = 1'b0;
        tick();
        $display("reset: released");
    endtask

    task automatic test_weights();
        logic [63:0] exp_w;
        for (int i = 0; i < 8; i++) begin
            w_model[i] = 64'h11 * 64'(i + 1);
            write_word(1'b0, w_model[i]);
        end
        for (int k = 0; k < 9; k++) begin
            resp_q.push_back(w_model[w_rd_idx]);
            w_rd_idx = (w_rd_idx + 1) % 8;
            req_pulse(1'b1, 1'b0);
            checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL wt_early_ready k=%0d got=%b exp=0", k, data_ready); end
            tick();
            exp_w = resp_q.pop_front();
            checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL wt_ready k=%0d got=%b exp=1", k, data_ready); end
            checks++; if (data !== exp_w) begin errors++; $display("FAIL wt_data k=%0d got=%h exp=%h", k, data, exp_w); end
            $display("weights: get %0d data=%h exp=%h", k, data, exp_w);
            tick();
        end
    endtask

    task automatic test_overflow();
        pulse_clr();
        for (int i = 0; i < 17; i++) begin
            if (i < 16) in_model[i] = 64'h100 + 64'(i);
            write_word(1'b1, 64'h100 + 64'(i));
        end
        checks++; if (num_inputs !== 8'd16) begin errors++; $display("FAIL ovf_num_inputs got=%0d exp=16", num_inputs); end
        checks++; if (occupancy_err !== 1'b1) begin errors++; $display("FAIL ovf_err got=%b exp=1", occupancy_err); end
        pulse_err_clr();
        checks++; if (occupancy_err !== 1'b0) begin errors++; $display("FAIL ovf_err_clr got=%b exp=0", occupancy_err); end
        $display("overflow: num_inputs=%0d err=%b", num_inputs, occupancy_err);
    endtask

    task automatic test_simultaneous();
        logic [63:0] exp_w;
        // Both requests: the weight wins; the input pointer must not move.
        resp_q.push_back(w_model[w_rd_idx]);
        w_rd_idx = (w_rd_idx + 1) % 8;
        req_pulse(1'b1, 1'b1);
        tick();
        exp_w = resp_q.pop_front();
        checks++; if (data_ready !== 1'b1 || data !== exp_w) begin errors++; $display("FAIL simul_weight got=%h/%b exp=%h/1", data, data_ready, exp_w); end
        $display("simultaneous: data=%h exp=%h", data, exp_w);
        tick();
        resp_q.push_back(in_model[0]);
        req_pulse(1'b0, 1'b1);
        tick();
        exp_w = resp_q.pop_front();
        checks++; if (data_ready !== 1'b1 || data !== exp_w) begin errors++; $display("FAIL simul_input_ptr got=%h/%b exp=%h/1", data, data_ready, exp_w); end
        $display("simultaneous: input data=%h exp=%h", data, exp_w);
        tick();
    endtask

    task automatic test_input_wrap();
        logic [63:0] exp_w;
        pulse_clr();
        for (int i = 0; i < 3; i++) begin
            in_model[i] = 64'hA0 + 64'(i);
            write_word(1'b1, in_model[i]);
        end
        for (int k = 0; k < 4; k++) begin
            resp_q.push_back(in_model[k % 3]);
            req_pulse(1'b0, 1'b1);
            tick();
            exp_w = resp_q.pop_front();
            checks++; if (data_ready !== 1'b1 || data !== exp_w) begin errors++; $display("FAIL in_wrap k=%0d got=%h/%b exp=%h/1", k, data, data_ready, exp_w); end
            $display("input_wrap: get %0d data=%h exp=%h", k, data, exp_w);
            tick();
        end
        // in_clr beats a same-cycle input write.
        in_clr = 1'b1; wr_en = 1'b1; wr_sel = 1'b1; wr_data = 64'hDEAD;
        tick();
        in_clr = 1'b0; wr_en = 1'b0;
        checks++; if (num_inputs !== 8'd0) begin errors++; $display("FAIL clr_priority got=%0d exp=0", num_inputs); end
        // Empty read: zero data, still a data_ready, error raised.
        resp_q.push_back(64'd0);
        req_pulse(1'b0, 1'b1);
        tick();
        exp_w = resp_q.pop_front();
        checks++; if (data_ready !== 1'b1 || data !== exp_w) begin errors++; $display("FAIL empty_read got=%h/%b exp=%h/1", data, data_ready, exp_w); end
        checks++; if (occupancy_err !== 1'b1) begin errors++; $display("FAIL empty_err got=%b exp=1", occupancy_err); end
        $display("empty_read: data=%h err=%b", data, occupancy_err);
        tick();
        pulse_err_clr();
    endtask

    task automatic test_output();
        logic [63:0] exp_w;
        int done_cnt;
        pulse_clr();
        for (int i = 0; i < 3; i++) begin
            in_model[i] = 64'hC0 + 64'(i);
            write_word(1'b1, in_model[i]);
        end
        for (int k = 0; k < 3; k++) begin
            array_out = {$urandom, $urandom};
            out_q.push_back(array_out);
            array_out_valid = 1'b1;
            tick();
            array_out_valid = 1'b0;
        end
        tick();
        checks++; if (output_valid !== 1'b1) begin errors++; $display("FAIL out_valid got=%b exp=1", output_valid); end
        get_out = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (out_done === 1'b1) done_cnt++;
        end
        get_out = 1'b0;
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL out_done_pulses got=%0d exp=1", done_cnt); end
        $display("output: out_done pulses=%0d", done_cnt);
        for (int k = 0; k < 3; k++) begin
            exp_w = out_q.pop_front();
            checks++; if (out_rd_data !== exp_w) begin errors++; $display("FAIL out_pop k=%0d got=%h exp=%h", k, out_rd_data, exp_w); end
            $display("output: pop %0d got=%h exp=%h", k, out_rd_data, exp_w);
            out_rd_en = 1'b1;
            tick();
            out_rd_en = 1'b0;
        end
        checks++; if (output_valid !== 1'b1) begin errors++; $display("FAIL out_valid_after_pop got=%b exp=1", output_valid); end
        // Pop on empty together with err_clr: err_clr must win.
        out_rd_en = 1'b1; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (occupancy_err !== 1'b0) begin errors++; $display("FAIL err_clr_wins got=%b exp=0", occupancy_err); end
        tick();
        out_rd_en = 1'b0;
        checks++; if (occupancy_err !== 1'b1) begin errors++; $display("FAIL pop_empty_err got=%b exp=1", occupancy_err); end
        pulse_err_clr();
        // A new pass (get_inputs at pointer 0) discards the old results.
        resp_q.push_back(in_model[0]);
        req_pulse(1'b0, 1'b1);
        checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL pass_clear got=%b exp=0", output_valid); end
        tick();
        exp_w = resp_q.pop_front();
        checks++; if (data !== exp_w) begin errors++; $display("FAIL pass_data got=%h exp=%h", data, exp_w); end
        tick();
        // Output region full: the 17th capture is dropped and flagged.
        pulse_clr();
        for (int k = 0; k < 17; k++) begin
            array_out = 64'hF000 + 64'(k);
            array_out_valid = 1'b1;
            tick();
        end
        array_out_valid = 1'b0;
        checks++; if (occupancy_err !== 1'b1) begin errors++; $display("FAIL cap_full_err got=%b exp=1", occupancy_err); end
        checks++; if (out_rd_data !== 64'hF000) begin errors++; $display("FAIL cap_full_head got=%h exp=%h", out_rd_data, 64'hF000); end
        $display("output: full err=%b head=%h", occupancy_err, out_rd_data);
        pulse_err_clr();
    endtask

    task automatic test_reset_mid();
        pulse_clr();
        write_word(1'b1, 64'h55);
        req_pulse(1'b1, 1'b0);
        // Now in READ.
        rst = 1'b1;
        #1;
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready got=%b exp=0", data_ready); end
        checks++; if (data !== 64'd0) begin errors++; $display("FAIL rst_mid_data got=%h exp=0", data); end
        checks++; if (num_inputs !== 8'd0) begin errors++; $display("FAIL rst_mid_num got=%0d exp=0", num_inputs); end
        checks++; if (output_valid !== 1'b0 || out_done !== 1'b0 || occupancy_err !== 1'b0) begin
            errors++; $display("FAIL rst_mid_flags got=%b%b%b exp=000", output_valid, out_done, occupancy_err);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_no_resp c=%0d got=%b exp=0", c, data_ready); end
        end
        $display("reset_mid: data_ready=%b data=%h", data_ready, data);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_data = '0; in_clr = 1'b0;
        err_clr = 1'b0; get_weights = 1'b0; get_inputs = 1'b0; get_out = 1'b0;
        array_out = '0; array_out_valid = 1'b0; out_rd_en = 1'b0;
        test_reset();
        test_weights();
        test_overflow();
        test_simultaneous();
        test_input_wrap();
        test_output();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
